flash_arbiter: RTL and testbench



---
 rtl/flash_arbiter.sv | 120 ++++++++++++
 tb/tb_flash_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/flash_arbiter.sv
// Arbitrates one flash read controller between a single-word CPU port and a streaming DMA port.
// Define FLASH_ARBITER_PREEMPT_EN to let a CPU request cut into a running DMA burst.
module flash_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_valid,
   input  logic [23:0] cpu_address,
   output logic        cpu_ready,
   output logic [31:0] cpu_rdata,
   input  logic        dma_start,
   input  logic [23:0] dma_address,
   input  logic [13:0] dma_length,
   output logic        dma_busy,
   output logic        dma_word_valid,
   output logic [31:0] dma_rdata,
   output logic        dma_done,
   output logic        flash_valid,
   output logic [23:0] flash_addr,
   output logic        flash_continue,
   input  logic        flash_ready,
   input  logic [31:0] flash_rdata
);

   localparam logic [23:0] WORD_MASK = 24'hFFFFFC;

   typedef enum logic [1:0] {IDLE, CPU, DMA, GAP} state_t;

   state_t      state, state_n;
   logic [23:0] dma_addr;
   logic [13:0] dma_left;
   logic        last_word;
   logic        preempt;

   assign last_word      = (dma_left == 14'd1);
   assign flash_valid    = (state == CPU) || (state == DMA);
   assign flash_continue = (state == DMA);

`ifdef FLASH_ARBITER_PREEMPT_EN
   // cpu_valid is held until served, so sampling it at each word boundary is enough
   assign preempt = cpu_valid;
`else
   assign preempt = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (cpu_valid)     state_n = CPU;
            else if (dma_busy) state_n = DMA;
         end
         CPU: if (flash_ready) state_n = GAP;
         DMA: if (flash_ready && (last_word || preempt)) state_n = GAP;
         GAP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpu_ready      <= 1'b0;
         cpu_rdata      <= '0;
         dma_busy       <= 1'b0;
         dma_word_valid <= 1'b0;
         dma_rdata      <= '0;
         dma_done       <= 1'b0;
         flash_addr     <= '0;
         dma_addr       <= '0;
         dma_left       <= '0;
      end else begin
         cpu_ready      <= 1'b0;
         dma_word_valid <= 1'b0;
         dma_done       <= 1'b0;

         // a zero-length start completes on the spot and never touches flash
         if (dma_start && !dma_busy) begin
            if (dma_length == 14'd0) begin
               dma_done <= 1'b1;
            end else begin
               dma_busy <= 1'b1;
               dma_addr <= dma_address & WORD_MASK;
               dma_left <= dma_length;
            end
         end

         case (state)
            IDLE: begin
               if (cpu_valid)     flash_addr <= cpu_address & WORD_MASK;
               else if (dma_busy) flash_addr <= dma_addr;
            end
            CPU: begin
               if (flash_ready) begin
                  cpu_rdata <= flash_rdata;
                  cpu_ready <= 1'b1;
               end
            end
            DMA: begin
               if (flash_ready) begin
                  dma_rdata      <= flash_rdata;
                  dma_word_valid <= 1'b1;
                  flash_addr     <= flash_addr + 24'd4;
                  dma_addr       <= dma_addr + 24'd4;
                  dma_left       <= dma_left - 14'd1;
                  if (last_word) begin
                     dma_done <= 1'b1;
                     dma_busy <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter; inputs driven and outputs sampled on the falling clock edge.
module tb_flash_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_valid = 1'b0;
   logic [23:0] cpu_address = '0;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic        dma_start = 1'b0;
   logic [23:0] dma_address = '0;
   logic [13:0] dma_length = '0;
   logic        dma_busy;
   logic        dma_word_valid;
   logic [31:0] dma_rdata;
   logic        dma_done;
   logic        flash_valid;
   logic [23:0] flash_addr;
   logic        flash_continue;
   logic        flash_ready = 1'b0;
   logic [31:0] flash_rdata = '0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   flash_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_valid(cpu_valid), .cpu_address(cpu_address), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .dma_start(dma_start), .dma_address(dma_address), .dma_length(dma_length),
      .dma_busy(dma_busy), .dma_word_valid(dma_word_valid), .dma_rdata(dma_rdata), .dma_done(dma_done),
      .flash_valid(flash_valid), .flash_addr(flash_addr), .flash_continue(flash_continue),
      .flash_ready(flash_ready), .flash_rdata(flash_rdata)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, " cpu_ready"}, 32'(cpu_ready), 32'd0);
      chk({tag, " dma_busy"}, 32'(dma_busy), 32'd0);
      chk({tag, " dma_word_valid"}, 32'(dma_word_valid), 32'd0);
      chk({tag, " dma_done"}, 32'(dma_done), 32'd0);
      chk({tag, " flash_valid"}, 32'(flash_valid), 32'd0);
      chk({tag, " flash_continue"}, 32'(flash_continue), 32'd0);
   endtask

   // one streamed DMA word: checks the request, returns data, checks the delivered word
   task automatic beat(input string tag, input logic [23:0] a, input logic [31:0] d,
                       input logic last, input logic fv_after);
      chk({tag, " fv"}, 32'(flash_valid), 32'd1);
      chk({tag, " cont"}, 32'(flash_continue), 32'd1);
      chk({tag, " addr"}, 32'(flash_addr), 32'(a));
      flash_ready = 1'b1;
      flash_rdata = d;
      tick();
      flash_ready = 1'b0;
      chk({tag, " wv"}, 32'(dma_word_valid), 32'd1);
      chk({tag, " rdata"}, dma_rdata, d);
      chk({tag, " done"}, 32'(dma_done), 32'(last));
      chk({tag, " busy"}, 32'(dma_busy), 32'(!last));
      chk({tag, " fv_after"}, 32'(flash_valid), 32'(fv_after));
   endtask

   task automatic start_dma(input logic [23:0] a, input logic [13:0] len);
      dma_start = 1'b1;
      dma_address = a;
      dma_length = len;
      tick();
      dma_start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      tick();
      chk_idle_outputs("reset");
      chk("reset cpu_rdata", cpu_rdata, 32'd0);
      chk("reset dma_rdata", dma_rdata, 32'd0);
      chk("reset flash_addr", 32'(flash_addr), 32'd0);
      reset = 1'b0;
      tick();

      // CPU read, low address bits dropped
      cpu_valid = 1'b1;
      cpu_address = 24'h100007;
      chk("cpu pre fv", 32'(flash_valid), 32'd0);
      tick();
      chk("cpu fv", 32'(flash_valid), 32'd1);
      chk("cpu addr", 32'(flash_addr), 32'h100004);
      chk("cpu cont", 32'(flash_continue), 32'd0);
      tick();
      chk("cpu wait ready", 32'(cpu_ready), 32'd0);
      flash_ready = 1'b1;
      flash_rdata = 32'hDEADBEEF;
      tick();
      flash_ready = 1'b0;
      chk("cpu ready", 32'(cpu_ready), 32'd1);
      chk("cpu rdata", cpu_rdata, 32'hDEADBEEF);
      chk("cpu gap fv", 32'(flash_valid), 32'd0);
      cpu_valid = 1'b0;
      tick();
      chk("cpu ready pulse", 32'(cpu_ready), 32'd0);
      chk("cpu rdata hold", cpu_rdata, 32'hDEADBEEF);
      chk("cpu idle fv", 32'(flash_valid), 32'd0);

      // 4-word burst
      start_dma(24'h100000, 14'd4);
      chk("dma4 busy", 32'(dma_busy), 32'd1);
      chk("dma4 pre fv", 32'(flash_valid), 32'd0);
      tick();
      for (int i = 0; i < 4; i++)
         beat($sformatf("dma4 w%0d", i), 24'h100000 + 24'(4 * i), 32'hA4000000 + 32'(i), i == 3, i != 3);
      tick();
      chk("dma4 idle fv", 32'(flash_valid), 32'd0);
      chk("dma4 wv pulse", 32'(dma_word_valid), 32'd0);
      chk("dma4 done pulse", 32'(dma_done), 32'd0);
      chk("cpu rdata untouched", cpu_rdata, 32'hDEADBEEF);

      // zero-length start
      start_dma(24'h123456, 14'd0);
      chk("len0 done", 32'(dma_done), 32'd1);
      chk("len0 busy", 32'(dma_busy), 32'd0);
      chk("len0 fv", 32'(flash_valid), 32'd0);
      tick();
      chk_idle_outputs("len0 after");
      tick();
      chk("len0 fv later", 32'(flash_valid), 32'd0);

      // wrapping burst, with an ignored start while busy
      start_dma(24'hFFFFF8, 14'd3);
      tick();
      beat("wrap w0", 24'hFFFFF8, 32'hB0000000, 1'b0, 1'b1);
      dma_start = 1'b1;
      dma_address = 24'h555550;
      dma_length = 14'd5;
      beat("wrap w1", 24'hFFFFFC, 32'hB0000001, 1'b0, 1'b1);
      dma_start = 1'b0;
      beat("wrap w2", 24'h000000, 32'hB0000002, 1'b1, 1'b0);
      tick();
      tick();
      chk_idle_outputs("wrap ignored start");

      // CPU request arriving during word 2 of an 8-word burst
      start_dma(24'h200000, 14'd8);
      tick();
      beat("pre w0", 24'h200000, 32'hC0000000, 1'b0, 1'b1);
      cpu_valid = 1'b1;
      cpu_address = 24'h300000;
`ifdef FLASH_ARBITER_PREEMPT_EN
      beat("pre w1", 24'h200004, 32'hC0000001, 1'b0, 1'b0);
      tick();
      chk("pre gap2 fv", 32'(flash_valid), 32'd0);
      tick();
      chk("pre cpu fv", 32'(flash_valid), 32'd1);
      chk("pre cpu addr", 32'(flash_addr), 32'h300000);
      chk("pre cpu cont", 32'(flash_continue), 32'd0);
      chk("pre busy held", 32'(dma_busy), 32'd1);
      flash_ready = 1'b1;
      flash_rdata = 32'hCAFEF00D;
      tick();
      flash_ready = 1'b0;
      cpu_valid = 1'b0;
      chk("pre cpu ready", 32'(cpu_ready), 32'd1);
      chk("pre cpu rdata", cpu_rdata, 32'hCAFEF00D);
      chk("pre dma rdata hold", dma_rdata, 32'hC0000001);
      chk("pre cpu gap fv", 32'(flash_valid), 32'd0);
      tick();
      chk("pre resume idle fv", 32'(flash_valid), 32'd0);
      tick();
      for (int i = 2; i < 8; i++)
         beat($sformatf("pre w%0d", i), 24'h200000 + 24'(4 * i), 32'hC0000000 + 32'(i), i == 7, i != 7);
      tick();
`else
      beat("pre w1", 24'h200004, 32'hC0000001, 1'b0, 1'b1);
      for (int i = 2; i < 8; i++) begin
         chk($sformatf("nopre cpu wait %0d", i), 32'(cpu_ready), 32'd0);
         beat($sformatf("pre w%0d", i), 24'h200000 + 24'(4 * i), 32'hC0000000 + 32'(i), i == 7, i != 7);
      end
      tick();
      chk("nopre idle fv", 32'(flash_valid), 32'd0);
      chk("nopre cpu not ready", 32'(cpu_ready), 32'd0);
      tick();
      chk("nopre cpu fv", 32'(flash_valid), 32'd1);
      chk("nopre cpu addr", 32'(flash_addr), 32'h300000);
      flash_ready = 1'b1;
      flash_rdata = 32'hCAFEF00D;
      tick();
      flash_ready = 1'b0;
      cpu_valid = 1'b0;
      chk("nopre cpu ready", 32'(cpu_ready), 32'd1);
      chk("nopre cpu rdata", cpu_rdata, 32'hCAFEF00D);
      chk("nopre dma rdata hold", dma_rdata, 32'hC0000007);
      tick();
`endif

      // reset while waiting on word 5 of a 10-word burst
      start_dma(24'h400000, 14'd10);
      tick();
      for (int i = 0; i < 4; i++)
         beat($sformatf("rst w%0d", i), 24'h400000 + 24'(4 * i), 32'hD0000000 + 32'(i), 1'b0, 1'b1);
      chk("rst pre addr", 32'(flash_addr), 32'h400010);
      #1 reset = 1'b1;
      #1;
      chk_idle_outputs("rst async");
      chk("rst async dma_rdata", dma_rdata, 32'd0);
      chk("rst async flash_addr", 32'(flash_addr), 32'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_idle_outputs($sformatf("rst after %0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
